// File: rtl/evt_builder.sv
// evt_builder: pairs charge (Q) and CFD time (t) words into event records
// and buffers them in a first-word fall-through FIFO for the readout side.
//
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   q_in/q_valid          31-bit charge word + single-cycle strobe
//   t_in/t_valid          38-bit time word + single-cycle strobe
//   evt_data/evt_valid    registered FIFO head {has_t, has_q, t, q}
//   evt_ready             consumer accepts the head record
//   fifo_level            records currently stored
//   drop_cnt              records lost on a full FIFO (saturating)
//   timeout_cnt           records written unpaired (saturating)
module evt_builder #(
  parameter int MATCH_WINDOW = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [30:0]        q_in,
  input  logic               q_valid,
  input  logic [37:0]        t_in,
  input  logic               t_valid,
  output logic [70:0]        evt_data,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        timeout_cnt
);

  localparam int              DEPTH = 1 << FIFO_AW;
  localparam logic [7:0]      WLAST = 8'(MATCH_WINDOW - 1);
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_T, WAIT_Q} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------
  // Pairing FSM. The record to write is registered here (wr_en/wr_rec),
  // so the FIFO write lands one edge after the deciding cycle.
  // ---------------------------------------------------------------------
  state_t       state;
  logic [7:0]   wcnt;
  logic [30:0]  q_pend;
  logic [37:0]  t_pend;
  logic         wr_en;
  logic [70:0]  wr_rec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      q_pend      <= '0;
      t_pend      <= '0;
      wr_en       <= 1'b0;
      wr_rec      <= '0;
      timeout_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (q_valid && t_valid) begin
            wr_en  <= 1'b1;
            wr_rec <= {2'b11, t_in, q_in};
          end else if (q_valid) begin
            q_pend <= q_in;
            wcnt   <= '0;
            state  <= WAIT_T;
          end else if (t_valid) begin
            t_pend <= t_in;
            wcnt   <= '0;
            state  <= WAIT_Q;
          end
        end
        WAIT_T: begin
          if (t_valid) begin
            wr_en  <= 1'b1;
            wr_rec <= {2'b11, t_in, q_pend};
            if (q_valid) begin
              q_pend <= q_in;
              wcnt   <= '0;
            end else begin
              state  <= IDLE;
            end
          end else if (q_valid) begin
            // A second Q replaces the pending one; the old one leaves unpaired.
            wr_en       <= 1'b1;
            wr_rec      <= {2'b01, 38'd0, q_pend};
            timeout_cnt <= sat_inc(timeout_cnt);
            q_pend      <= q_in;
            wcnt        <= '0;
          end else if (wcnt == WLAST) begin
            wr_en       <= 1'b1;
            wr_rec      <= {2'b01, 38'd0, q_pend};
            timeout_cnt <= sat_inc(timeout_cnt);
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        WAIT_Q: begin
          if (q_valid) begin
            wr_en  <= 1'b1;
            wr_rec <= {2'b11, t_pend, q_in};
            if (t_valid) begin
              t_pend <= t_in;
              wcnt   <= '0;
            end else begin
              state  <= IDLE;
            end
          end else if (t_valid) begin
            wr_en       <= 1'b1;
            wr_rec      <= {2'b10, t_pend, 31'd0};
            timeout_cnt <= sat_inc(timeout_cnt);
            t_pend      <= t_in;
            wcnt        <= '0;
          end else if (wcnt == WLAST) begin
            wr_en       <= 1'b1;
            wr_rec      <= {2'b10, t_pend, 31'd0};
            timeout_cnt <= sat_inc(timeout_cnt);
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO. evt_data is a registered shadow of mem[rd_ptr], so evt_valid is
  // simply (level != 0) one edge later.
  // ---------------------------------------------------------------------
  logic [70:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
  logic             full, rd, push;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == FULL_LVL);
  assign rd         = evt_valid && evt_ready;
  // A read in the same cycle frees the slot for a write into a full FIFO.
  assign push       = wr_en && (!full || rd);
  assign wr_ptr_n   = wr_ptr + {{FIFO_AW{1'b0}}, push};
  assign rd_ptr_n   = rd_ptr + {{FIFO_AW{1'b0}}, rd};
  assign level_n    = wr_ptr_n - rd_ptr_n;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= wr_rec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      evt_valid <= (level_n != '0);
      // Bypass when the new head is the slot being written this edge.
      if (level_n == '0)
        evt_data <= '0;
      else if (push && (wr_ptr[FIFO_AW-1:0] == rd_ptr_n[FIFO_AW-1:0]))
        evt_data <= wr_rec;
      else
        evt_data <= mem[rd_ptr_n[FIFO_AW-1:0]];
      if (wr_en && full && !rd) drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_evt_builder.sv
// Self-checking bench for evt_builder: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_evt_builder;

  localparam int MW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef logic [70:0] rec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [30:0]   q_in;
  logic          q_valid;
  logic [37:0]   t_in;
  logic          t_valid;
  logic [70:0]   evt_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [AW:0]   fifo_level;
  logic [15:0]   drop_cnt;
  logic [15:0]   timeout_cnt;

  evt_builder #(.MATCH_WINDOW(MW), .FIFO_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .q_in(q_in), .q_valid(q_valid),
    .t_in(t_in), .t_valid(t_valid),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
  );

  always #8 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input rec_t got, input rec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: records in flight, queue contents, pending words
  rec_t        mq[$];
  bit          fl_v;
  rec_t        fl_r;
  bit          pq_v, pt_v;
  logic [30:0] pq;
  logic [37:0] pt;
  int          p_cyc;      // cycle in which the pending word arrived
  int          cyc;
  int          m_drop, m_tmo;

  function automatic rec_t mk(bit ht, bit hq, logic [37:0] t, logic [30:0] q);
    return {ht, hq, t, q};
  endfunction

  function automatic int sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    mq.delete();
    fl_v = 0; pq_v = 0; pt_v = 0; m_drop = 0; m_tmo = 0;
  endtask

  // One clock edge worth of behaviour, using this cycle's inputs.
  task automatic model_update(bit qv, logic [30:0] q, bit tv, logic [37:0] t, bit rdy);
    bit rdx  = (mq.size() > 0) && rdy;
    bit full = (mq.size() == DEPTH);
    if (rdx) void'(mq.pop_front());
    if (fl_v) begin
      if (full && !rdx) m_drop = sat(m_drop);
      else mq.push_back(fl_r);
    end
    fl_v = 0;
    if (pq_v) begin
      if (tv) begin
        fl_v = 1; fl_r = mk(1, 1, t, pq);
        if (qv) begin pq = q; p_cyc = cyc; end else pq_v = 0;
      end else if (qv) begin
        fl_v = 1; fl_r = mk(0, 1, 38'd0, pq); m_tmo = sat(m_tmo);
        pq = q; p_cyc = cyc;
      end else if (cyc - p_cyc == MW) begin
        fl_v = 1; fl_r = mk(0, 1, 38'd0, pq); m_tmo = sat(m_tmo); pq_v = 0;
      end
    end else if (pt_v) begin
      if (qv) begin
        fl_v = 1; fl_r = mk(1, 1, pt, q);
        if (tv) begin pt = t; p_cyc = cyc; end else pt_v = 0;
      end else if (tv) begin
        fl_v = 1; fl_r = mk(1, 0, pt, 31'd0); m_tmo = sat(m_tmo);
        pt = t; p_cyc = cyc;
      end else if (cyc - p_cyc == MW) begin
        fl_v = 1; fl_r = mk(1, 0, pt, 31'd0); m_tmo = sat(m_tmo); pt_v = 0;
      end
    end else begin
      if (qv && tv) begin fl_v = 1; fl_r = mk(1, 1, t, q); end
      else if (qv) begin pq_v = 1; pq = q; p_cyc = cyc; end
      else if (tv) begin pt_v = 1; pt = t; p_cyc = cyc; end
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("valid", 71'(evt_valid), 71'(mq.size() != 0));
    if (mq.size() != 0) chk("data", evt_data, mq[0]);
    chk("level", 71'(fifo_level), 71'(mq.size()));
    chk("drop", 71'(drop_cnt), 71'(m_drop));
    chk("tmo", 71'(timeout_cnt), 71'(m_tmo));
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance the model.
  task automatic tick(bit qv, logic [30:0] q, bit tv, logic [37:0] t, bit rdy);
    q_valid = qv; q_in = q; t_valid = tv; t_in = t; evt_ready = rdy;
    @(negedge clk);
    compare_all();
    model_update(qv, q, tv, t, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) tick(0, 31'd0, 0, 38'd0, rdy);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_valid"}, 71'(evt_valid), 71'(0));
    chk({tag, "_data"},  evt_data, 71'(0));
    chk({tag, "_level"}, 71'(fifo_level), 71'(0));
    chk({tag, "_drop"},  71'(drop_cnt), 71'(0));
    chk({tag, "_tmo"},   71'(timeout_cnt), 71'(0));
  endtask

  initial begin
    reset_n = 1'b0; q_valid = 0; t_valid = 0; q_in = '0; t_in = '0; evt_ready = 0;
    cyc = 0; p_cyc = 0;
    model_clear();
    #3;
    check_reset_state("por");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // paired arrival
    tick(1, 31'h100, 1, 38'h5, 1);
    idle(5, 1);
    // skewed pair, t five cycles after q
    tick(1, 31'h20, 0, 38'd0, 1);
    idle(4, 1);
    tick(0, 31'd0, 1, 38'h7, 1);
    idle(5, 1);
    chk("skew_tmo", 71'(timeout_cnt), 71'(0));
    // lone t times out
    tick(0, 31'd0, 1, 38'h9, 1);
    idle(22, 1);
    chk("lone_tmo", 71'(timeout_cnt), 71'(1));
    // back-to-back Q
    tick(1, 31'h1, 0, 38'd0, 1);
    idle(2, 1);
    tick(1, 31'h2, 0, 38'd0, 1);
    idle(1, 1);
    tick(0, 31'd0, 1, 38'h3, 1);
    idle(5, 1);
    chk("b2b_tmo", 71'(timeout_cnt), 71'(2));

    // overflow with consumer stalled, then drain with random stalls
    for (int i = 0; i < 20; i++) tick(1, 31'(32'h1000 + i), 1, 38'(i), 0);
    idle(3, 0);
    chk("ovf_level", 71'(fifo_level), 71'(16));
    chk("ovf_drop", 71'(drop_cnt), 71'(4));
    for (int i = 0; i < 80; i++) tick(0, 31'd0, 0, 38'd0, bit'($urandom_range(0, 1)));
    idle(4, 1);
    chk("drain_level", 71'(fifo_level), 71'(0));

    // reset mid-operation: 5 records stored, Q pending
    for (int i = 0; i < 5; i++) tick(1, 31'(i + 7), 1, 38'(i + 9), 0);
    tick(1, 31'h55, 0, 38'd0, 0);
    idle(2, 0);
    #4;
    reset_n = 1'b0;
    #1;
    check_reset_state("mid");
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    tick(0, 31'd0, 1, 38'h44, 1);
    idle(20, 1);
    chk("fresh_tmo", 71'(timeout_cnt), 71'(1));

    // random traffic in phases of varying density and consumer speed
    for (int ph = 0; ph < 8; ph++) begin
      int sp = $urandom_range(5, 60);
      int rp = $urandom_range(10, 100);
      for (int i = 0; i < 500; i++) begin
        bit qv = ($urandom_range(0, 99) < sp);
        bit tv = ($urandom_range(0, 99) < sp);
        bit r  = ($urandom_range(0, 99) < rp);
        tick(qv, 31'($urandom), tv, {6'($urandom), 32'($urandom)}, r);
      end
    end
    idle(40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
